// File: rtl/pipes_pkg.sv
// Shared definitions for the dual-issue SPU-style pipeline: opcodes, field
// widths, register-file types, decoded operation enums and small helpers.
package pipes_pkg;

    localparam int NUM_REGS   = 128;
    localparam int REG_WIDTH  = 128;
    localparam int ADDR_W     = 7;
    localparam int HALF_W     = 16;
    localparam int NUM_HALVES = REG_WIDTH / HALF_W;
    localparam int PC_W       = 8;
    localparam int OP11_W     = 11;
    localparam int OP9_W      = 9;
    localparam int I16_W      = 16;

    localparam logic [0:OP11_W-1] OP_NOP   = 11'b01000000001;
    localparam logic [0:OP11_W-1] OP_AH    = 11'b00011001000;
    localparam logic [0:OP11_W-1] OP_SHLHI = 11'b00001111111;
    localparam logic [0:OP11_W-1] OP_ROTH  = 11'b00001011100;
    localparam logic [0:OP11_W-1] OP_ROTHI = 11'b00001111100;
    localparam logic [0:OP11_W-1] OP_LNOP  = 11'b00000000001;
    localparam logic [0:OP9_W-1]  OP_ILH   = 9'b010000011;
    localparam logic [0:OP9_W-1]  OP_BR    = 9'b001100100;
    localparam logic [0:OP9_W-1]  OP_BRZ   = 9'b001000000;
    localparam logic [0:OP9_W-1]  OP_BRNZ  = 9'b001000010;

    // Read-port numbering of the register file
    localparam int RD_EVEN_RA     = 0;
    localparam int RD_EVEN_RB     = 1;
    localparam int RD_EVEN_RC     = 2;
    localparam int RD_ODD_RA      = 3;
    localparam int RD_ODD_RT      = 4;
    localparam int NUM_READ_PORTS = 5;

    typedef logic [0:REG_WIDTH-1] quadword_t;
    typedef quadword_t reg_array_t [NUM_REGS];

    typedef enum logic [2:0] {
        EVEN_NOP,
        EVEN_ILH,
        EVEN_AH,
        EVEN_SHLHI,
        EVEN_ROTH,
        EVEN_ROTHI
    } even_op_e;

    typedef enum logic [1:0] {
        ODD_NOP,
        ODD_BR,
        ODD_BRZ,
        ODD_BRNZ
    } odd_op_e;

    function automatic even_op_e decode_even(input logic [0:OP11_W-1] op);
        even_op_e dec;
        dec = EVEN_NOP;
        if (op[0:OP9_W-1] == OP_ILH) begin
            dec = EVEN_ILH;
        end else begin
            case (op)
                OP_NOP:   dec = EVEN_NOP;
                OP_AH:    dec = EVEN_AH;
                OP_SHLHI: dec = EVEN_SHLHI;
                OP_ROTH:  dec = EVEN_ROTH;
                OP_ROTHI: dec = EVEN_ROTHI;
                default:  dec = EVEN_NOP;
            endcase
        end
        return dec;
    endfunction

    function automatic odd_op_e decode_odd(input logic [0:OP11_W-1] op);
        odd_op_e dec;
        dec = ODD_NOP;
        if (op != OP_LNOP) begin
            case (op[0:OP9_W-1])
                OP_BR:   dec = ODD_BR;
                OP_BRZ:  dec = ODD_BRZ;
                OP_BRNZ: dec = ODD_BRNZ;
                default: dec = ODD_NOP;
            endcase
        end
        return dec;
    endfunction

    // A zero rotate amount shifts right by 16, which yields 0 and leaves v intact
    function automatic logic [HALF_W-1:0] rotl16(input logic [HALF_W-1:0] v,
                                                 input logic [3:0] n);
        return (v << n) | (v >> (5'd16 - {1'b0, n}));
    endfunction

endpackage

// File: rtl/pipes_if.sv
// Instruction-pair input and write-back/branch output bundle of the pipes block.
interface pipes_if;
    import pipes_pkg::*;

    logic [0:31]       instruction_even;
    logic [0:31]       instruction_odd;
    logic [PC_W-1:0]   program_counter;
    logic [PC_W-1:0]   program_counter_wb;
    logic              branch_is_taken;
    quadword_t         rt_even_wb;
    quadword_t         rt_odd_wb;
    logic [ADDR_W-1:0] rt_address_even_wb;
    logic [ADDR_W-1:0] rt_address_odd_wb;
    logic              register_write_even_wb;
    logic              register_write_odd_wb;

    modport master (
        output instruction_even, instruction_odd, program_counter,
        input  program_counter_wb, branch_is_taken,
        input  rt_even_wb, rt_odd_wb, rt_address_even_wb, rt_address_odd_wb,
        input  register_write_even_wb, register_write_odd_wb
    );

    modport slave (
        input  instruction_even, instruction_odd, program_counter,
        output program_counter_wb, branch_is_taken,
        output rt_even_wb, rt_odd_wb, rt_address_even_wb, rt_address_odd_wb,
        output register_write_even_wb, register_write_odd_wb
    );

endinterface

// File: rtl/spu_register_file.sv
// 128 x 128-bit register file with two write ports and five combinational
// read ports; the even write port wins when both target one register.
module spu_register_file
    import pipes_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en_even,
    input  logic [ADDR_W-1:0] wr_addr_even,
    input  quadword_t         wr_data_even,
    input  logic              wr_en_odd,
    input  logic [ADDR_W-1:0] wr_addr_odd,
    input  quadword_t         wr_data_odd,
    input  logic [ADDR_W-1:0] rd_addr [NUM_READ_PORTS],
    output quadword_t         rd_data [NUM_READ_PORTS]
);

    reg_array_t regs;

    // Even write is issued last so it overrides an odd write to the same register
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_en_odd) begin
                regs[wr_addr_odd] <= wr_data_odd;
            end
            if (wr_en_even) begin
                regs[wr_addr_even] <= wr_data_even;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            rd_data[p] = regs[rd_addr[p]];
        end
    end

endmodule

// File: rtl/pipes.sv
// Dual-issue pipeline: operands are read (with forwarding) as a pair is sampled,
// executed in stage 1, registered to write-back, then committed to the register file.
module pipes
    import pipes_pkg::*;
(
    input logic   clock,
    input logic   reset,
    pipes_if.slave bus
);

    even_op_e          dec_even;
    odd_op_e           dec_odd;
    logic [ADDR_W-1:0] even_ra_addr;
    logic [ADDR_W-1:0] even_rb_addr;
    logic [ADDR_W-1:0] odd_rt_addr;

    logic [ADDR_W-1:0] rd_addr [NUM_READ_PORTS];
    quadword_t         rd_data [NUM_READ_PORTS];

    quadword_t         fwd_ra;
    quadword_t         fwd_rb;
    logic [0:31]       fwd_rt_word;

    even_op_e          s1_even_op;
    logic [ADDR_W-1:0] s1_even_rt;
    quadword_t         s1_ra_val;
    quadword_t         s1_rb_val;
    logic [I16_W-1:0]  s1_i16;
    logic [4:0]        s1_i7;
    odd_op_e           s1_odd_op;
    logic [0:31]       s1_rt_word;
    logic [PC_W-1:0]   s1_pc;
    logic [I16_W-1:0]  s1_odd_i16;

    quadword_t         even_result;
    logic              even_writes;
    logic              branch_taken;
    logic [PC_W-1:0]   branch_target;

    assign dec_even     = decode_even(bus.instruction_even[0:10]);
    assign dec_odd      = decode_odd(bus.instruction_odd[0:10]);
    assign even_ra_addr = bus.instruction_even[18:24];
    assign even_rb_addr = bus.instruction_even[11:17];
    assign odd_rt_addr  = bus.instruction_odd[25:31];

    assign rd_addr[RD_EVEN_RA] = even_ra_addr;
    assign rd_addr[RD_EVEN_RB] = even_rb_addr;
    assign rd_addr[RD_EVEN_RC] = bus.instruction_even[25:31];
    assign rd_addr[RD_ODD_RA]  = bus.instruction_odd[18:24];
    assign rd_addr[RD_ODD_RT]  = odd_rt_addr;

    spu_register_file u_register_file (
        .clock        (clock),
        .reset        (reset),
        .wr_en_even   (bus.register_write_even_wb),
        .wr_addr_even (bus.rt_address_even_wb),
        .wr_data_even (bus.rt_even_wb),
        .wr_en_odd    (bus.register_write_odd_wb),
        .wr_addr_odd  (bus.rt_address_odd_wb),
        .wr_data_odd  (bus.rt_odd_wb),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data)
    );

    function automatic logic [HALF_W-1:0] exec_half(input even_op_e         op,
                                                    input logic [HALF_W-1:0] a,
                                                    input logic [HALF_W-1:0] b,
                                                    input logic [I16_W-1:0]  i16,
                                                    input logic [4:0]        i7);
        logic [HALF_W-1:0] r;
        case (op)
            EVEN_ILH:   r = i16;
            EVEN_AH:    r = a + b;
            EVEN_SHLHI: r = i7[4] ? '0 : (a << i7[3:0]);
            EVEN_ROTH:  r = rotl16(a, b[3:0]);
            EVEN_ROTHI: r = rotl16(a, i7[3:0]);
            default:    r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        even_result = '0;
        even_writes = (s1_even_op != EVEN_NOP);
        for (int h = 0; h < NUM_HALVES; h++) begin
            even_result[h*HALF_W +: HALF_W] = exec_half(s1_even_op,
                                                        s1_ra_val[h*HALF_W +: HALF_W],
                                                        s1_rb_val[h*HALF_W +: HALF_W],
                                                        s1_i16, s1_i7);
        end
    end

    // Later assignments take priority: stage-1 result, then write-back, then register file
    always_comb begin
        fwd_ra      = rd_data[RD_EVEN_RA];
        fwd_rb      = rd_data[RD_EVEN_RB];
        fwd_rt_word = rd_data[RD_ODD_RT][0:31];
        if (bus.register_write_even_wb) begin
            if (bus.rt_address_even_wb == even_ra_addr) fwd_ra = bus.rt_even_wb;
            if (bus.rt_address_even_wb == even_rb_addr) fwd_rb = bus.rt_even_wb;
            if (bus.rt_address_even_wb == odd_rt_addr)  fwd_rt_word = bus.rt_even_wb[0:31];
        end
        if (even_writes) begin
            if (s1_even_rt == even_ra_addr) fwd_ra = even_result;
            if (s1_even_rt == even_rb_addr) fwd_rb = even_result;
            if (s1_even_rt == odd_rt_addr)  fwd_rt_word = even_result[0:31];
        end
    end

    // A pair sampled while a branch is being taken is squashed to nops
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_even_op <= EVEN_NOP;
            s1_even_rt <= '0;
            s1_ra_val  <= '0;
            s1_rb_val  <= '0;
            s1_i16     <= '0;
            s1_i7      <= '0;
            s1_odd_op  <= ODD_NOP;
            s1_rt_word <= '0;
            s1_pc      <= '0;
            s1_odd_i16 <= '0;
        end else begin
            s1_even_op <= branch_taken ? EVEN_NOP : dec_even;
            s1_even_rt <= bus.instruction_even[25:31];
            s1_ra_val  <= fwd_ra;
            s1_rb_val  <= fwd_rb;
            s1_i16     <= bus.instruction_even[9:24];
            s1_i7      <= bus.instruction_even[13:17];
            s1_odd_op  <= branch_taken ? ODD_NOP : dec_odd;
            s1_rt_word <= fwd_rt_word;
            s1_pc      <= bus.program_counter;
            s1_odd_i16 <= bus.instruction_odd[9:24];
        end
    end

    always_comb begin
        branch_taken = 1'b0;
        case (s1_odd_op)
            ODD_BR:   branch_taken = 1'b1;
            ODD_BRZ:  branch_taken = (s1_rt_word == '0);
            ODD_BRNZ: branch_taken = (s1_rt_word != '0);
            default:  branch_taken = 1'b0;
        endcase
    end

    assign branch_target          = PC_W'({8'h00, s1_pc} + s1_odd_i16);
    assign bus.branch_is_taken    = branch_taken;
    assign bus.program_counter_wb = branch_taken ? branch_target : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.rt_even_wb             <= '0;
            bus.rt_address_even_wb     <= '0;
            bus.register_write_even_wb <= 1'b0;
        end else begin
            bus.rt_even_wb             <= even_result;
            bus.rt_address_even_wb     <= even_writes ? s1_even_rt : '0;
            bus.register_write_even_wb <= even_writes;
        end
    end

    // No odd-pipe operation produces register data
    assign bus.rt_odd_wb             = '0;
    assign bus.rt_address_odd_wb     = '0;
    assign bus.register_write_odd_wb = 1'b0;

endmodule

// File: tb/tb_pipes.sv
// Self-checking bench for pipes: directed scenarios followed by random pairs,
// compared against a sequential instruction-level model of the register file.
module tb_pipes;

    localparam logic [0:10] T_NOP   = 11'b01000000001;
    localparam logic [0:10] T_LNOP  = 11'b00000000001;
    localparam logic [0:10] T_AH    = 11'b00011001000;
    localparam logic [0:10] T_SHLHI = 11'b00001111111;
    localparam logic [0:10] T_ROTH  = 11'b00001011100;
    localparam logic [0:10] T_ROTHI = 11'b00001111100;
    localparam logic [0:8]  T_ILH   = 9'b010000011;
    localparam logic [0:8]  T_BR    = 9'b001100100;
    localparam logic [0:8]  T_BRZ   = 9'b001000000;
    localparam logic [0:8]  T_BRNZ  = 9'b001000010;

    logic clock;
    logic reset;

    pipes_if bus ();

    pipes dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors_applied;
    int miscompares;

    logic [0:127] model_regs [128];
    bit           flush_pending;
    logic [0:127] exp_wb_data;
    logic [6:0]   exp_wb_addr;
    bit           exp_wb_we;

    function automatic logic [0:31] enc_rr(input logic [0:10] op, input int rb,
                                           input int ra, input int rt);
        return {op, 7'(rb), 7'(ra), 7'(rt)};
    endfunction

    function automatic logic [0:31] enc_ri16(input logic [0:8] op, input int imm,
                                             input int rt);
        return {op, 16'(imm), 7'(rt)};
    endfunction

    // Architectural meaning of one even instruction, halfword by halfword
    function automatic logic [0:127] model_even(input logic [0:31] w,
                                                input logic [0:127] ra_v,
                                                input logic [0:127] rb_v,
                                                output bit writes);
        logic [0:127] res;
        int a, b, n, r, i7;
        res    = '0;
        writes = 1'b1;
        i7     = int'(w[11:17]);
        for (int h = 0; h < 8; h++) begin
            a = int'(ra_v[h*16 +: 16]);
            b = int'(rb_v[h*16 +: 16]);
            r = 0;
            if (w[0:8] == T_ILH) begin
                r = int'(w[9:24]);
            end else if (w[0:10] == T_AH) begin
                r = (a + b) % 65536;
            end else if (w[0:10] == T_SHLHI) begin
                n = i7 % 32;
                r = (n >= 16) ? 0 : (a << n) % 65536;
            end else if (w[0:10] == T_ROTH) begin
                n = b % 16;
                r = ((a << n) | (a >> (16 - n))) % 65536;
            end else if (w[0:10] == T_ROTHI) begin
                n = i7 % 16;
                r = ((a << n) | (a >> (16 - n))) % 65536;
            end else begin
                writes = 1'b0;
            end
            res[h*16 +: 16] = 16'(r);
        end
        return writes ? res : '0;
    endfunction

    task automatic check_output(input string tag, input logic [127:0] observed,
                                input logic [127:0] expected);
        vectors_applied++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 128; i++) model_regs[i] = '0;
        flush_pending = 1'b0;
        exp_wb_data   = '0;
        exp_wb_addr   = '0;
        exp_wb_we     = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        reset                = 1'b1;
        bus.instruction_even = '0;
        bus.instruction_odd  = '0;
        bus.program_counter  = '0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clock);
            #1;
            check_output("reset_rt_even_wb", 128'(bus.rt_even_wb), '0);
            check_output("reset_rt_address_even_wb", 128'(bus.rt_address_even_wb), '0);
            check_output("reset_register_write_even_wb", 128'(bus.register_write_even_wb), '0);
            check_output("reset_rt_odd_wb", 128'(bus.rt_odd_wb), '0);
            check_output("reset_register_write_odd_wb", 128'(bus.register_write_odd_wb), '0);
            check_output("reset_branch_is_taken", 128'(bus.branch_is_taken), '0);
            check_output("reset_program_counter_wb", 128'(bus.program_counter_wb), '0);
        end
        reset = 1'b0;
        model_clear();
    endtask

    // Presents one pair, then checks its branch outputs and the previous pair's write-back
    task automatic apply_stimulus(input logic [0:31] ie, input logic [0:31] io,
                                  input logic [7:0] pc);
        logic [0:127] res;
        bit           writes;
        bit           taken;
        logic [7:0]   target;
        logic [6:0]   rt;
        bus.instruction_even = ie;
        bus.instruction_odd  = io;
        bus.program_counter  = pc;
        @(posedge clock);
        #1;
        taken  = 1'b0;
        target = '0;
        res    = '0;
        writes = 1'b0;
        rt     = ie[25:31];
        if (!flush_pending) begin
            if (io[0:8] == T_BR)
                taken = 1'b1;
            else if (io[0:8] == T_BRZ)
                taken = (model_regs[io[25:31]][0:31] == 32'd0);
            else if (io[0:8] == T_BRNZ)
                taken = (model_regs[io[25:31]][0:31] != 32'd0);
            target = 8'((int'(pc) + int'(io[9:24])) % 256);
            res = model_even(ie, model_regs[ie[18:24]], model_regs[ie[11:17]], writes);
            if (writes) model_regs[rt] = res;
        end
        check_output("branch_is_taken", 128'(bus.branch_is_taken), 128'(taken));
        check_output("program_counter_wb", 128'(bus.program_counter_wb),
                     128'(taken ? target : 8'd0));
        check_output("rt_even_wb", bus.rt_even_wb, exp_wb_data);
        check_output("rt_address_even_wb", 128'(bus.rt_address_even_wb), 128'(exp_wb_addr));
        check_output("register_write_even_wb", 128'(bus.register_write_even_wb),
                     128'(exp_wb_we));
        check_output("register_write_odd_wb", 128'(bus.register_write_odd_wb), '0);
        exp_wb_data   = writes ? res : '0;
        exp_wb_addr   = writes ? rt : 7'd0;
        exp_wb_we     = writes;
        flush_pending = taken;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [0:31] lnop;
        logic [0:31] ie;
        logic [0:31] io;
        int sel, osel, rt, ra, rb, imm, i7;

        vectors_applied = 0;
        miscompares     = 0;
        lnop            = enc_rr(T_LNOP, 0, 0, 0);
        model_clear();

        apply_reset(2);

        apply_stimulus(enc_ri16(T_ILH, 16'h1234, 3), lnop, 8'd0);
        apply_stimulus(enc_rr(T_AH, 3, 3, 5), lnop, 8'd1);
        check_output("ilh_r3_data", bus.rt_even_wb, {8{16'h1234}});
        check_output("ilh_r3_addr", 128'(bus.rt_address_even_wb), 128'(7'd3));
        check_output("ilh_r3_we", 128'(bus.register_write_even_wb), 128'(1'b1));
        apply_stimulus(enc_ri16(T_ILH, 16'hF00F, 4), lnop, 8'd2);
        check_output("ah_forward_data", bus.rt_even_wb, {8{16'h2468}});
        apply_stimulus(enc_rr(T_AH, 4, 3, 6), lnop, 8'd3);
        apply_stimulus(enc_rr(T_SHLHI, 4, 3, 7), lnop, 8'd4);
        check_output("ah_wrap_data", bus.rt_even_wb, {8{16'h0243}});
        apply_stimulus(enc_rr(T_SHLHI, 16, 3, 7), lnop, 8'd5);
        check_output("shlhi_4_data", bus.rt_even_wb, {8{16'h2340}});
        apply_stimulus(enc_rr(T_ROTHI, 4, 3, 8), lnop, 8'd6);
        check_output("shlhi_16_data", bus.rt_even_wb, '0);

        apply_stimulus(enc_rr(T_NOP, 0, 0, 0), enc_ri16(T_BR, 5, 0), 8'd10);
        check_output("rothi_4_data", bus.rt_even_wb, {8{16'h2341}});
        check_output("br_taken", 128'(bus.branch_is_taken), 128'(1'b1));
        check_output("br_target", 128'(bus.program_counter_wb), 128'(8'd15));
        apply_stimulus(enc_ri16(T_ILH, 16'h5555, 9), enc_ri16(T_BR, 7, 0), 8'd11);
        check_output("flushed_br_taken", 128'(bus.branch_is_taken), 128'(1'b0));
        apply_stimulus(enc_rr(T_AH, 9, 9, 10), lnop, 8'd15);
        check_output("flushed_ilh_we", 128'(bus.register_write_even_wb), 128'(1'b0));
        apply_stimulus(enc_rr(T_NOP, 0, 0, 0), lnop, 8'd16);
        check_output("flushed_r9_unwritten", bus.rt_even_wb, '0);

        apply_stimulus(enc_rr(T_NOP, 0, 0, 0), enc_ri16(T_BRZ, 100, 20), 8'd200);
        check_output("brz_wrap_target", 128'(bus.program_counter_wb), 128'(8'd44));
        apply_stimulus(enc_rr(T_NOP, 0, 0, 0), enc_ri16(T_BRNZ, 16'hFFFF, 3), 8'd44);
        apply_stimulus(enc_ri16(T_ILH, 0, 12), enc_ri16(T_BRNZ, 16'hFFFF, 3), 8'd45);
        apply_stimulus(enc_rr(T_NOP, 0, 0, 0), enc_ri16(T_BRZ, 3, 12), 8'd46);
        apply_stimulus(enc_rr(T_ROTH, 6, 3, 13), enc_ri16(T_BRZ, 3, 6), 8'd47);

        apply_stimulus(enc_ri16(T_ILH, 16'hABCD, 10), lnop, 8'd50);
        apply_reset(1);
        apply_stimulus(enc_rr(T_AH, 10, 10, 11), lnop, 8'd0);
        apply_stimulus(enc_rr(T_NOP, 0, 0, 0), lnop, 8'd1);
        check_output("reset_inflight_r10_data", bus.rt_even_wb, '0);
        check_output("reset_inflight_r11_we", 128'(bus.register_write_even_wb), 128'(1'b1));

        for (int k = 0; k < 300; k++) begin
            sel  = $urandom_range(0, 6);
            osel = $urandom_range(0, 9);
            rt   = $urandom_range(0, 7);
            ra   = $urandom_range(0, 7);
            rb   = $urandom_range(0, 7);
            imm  = $urandom_range(0, 65535);
            i7   = $urandom_range(0, 127);
            case (sel)
                0:       ie = enc_rr(T_NOP, rb, ra, rt);
                1:       ie = enc_ri16(T_ILH, imm, rt);
                2:       ie = enc_rr(T_AH, rb, ra, rt);
                3:       ie = enc_rr(T_SHLHI, i7, ra, rt);
                4:       ie = enc_rr(T_ROTH, rb, ra, rt);
                5:       ie = enc_rr(T_ROTHI, i7, ra, rt);
                default: ie = $urandom();
            endcase
            case (osel)
                4:       io = enc_ri16(T_BR, imm, rt);
                5, 6:    io = enc_ri16(T_BRZ, imm, rb);
                7, 8:    io = enc_ri16(T_BRNZ, imm, rb);
                9:       io = $urandom();
                default: io = lnop;
            endcase
            apply_stimulus(ie, io, 8'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
